sine_width_gen: RTL
===================

SINE_WIDTH_GEN -- requirements
Module: sine_width_gen

Interface
REQ-001 SHALL have parameter TICK_MAX, default 1000: clk cycles per sample tick; legal range >=2.
REQ-002 SHALL have parameter ADDR_W, default 6: full-wave table address width; quarter size Q = 2^(ADDR_W-2); legal range >=3.
REQ-003 SHALL have parameter DATA_W, default 32: output width; HALF = 2^(DATA_W-1)-1.
REQ-004 SHALL have parameter PHASE_W, default 16: phase accumulator width; PHASE_W >= ADDR_W.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1: tick counter runs while high.
REQ-008 SHALL have port phase_inc, input, PHASE_W: phase step per tick (frequency control).
REQ-009 SHALL have port amp, input, 8: amplitude scale; effective factor (amp+1)/256.
REQ-010 SHALL have port sync_zero, input, 1: single-cycle phase restart request.
REQ-011 SHALL have port widthSine, output, DATA_W: PWM width sample.
REQ-012 SHALL have port sample_valid, output, 1: one-cycle pulse on each widthSine update.

Function
REQ-013 Tick counter SHALL count 0..TICK_MAX-1 while enable=1, wrap to 0, and assert internal tick in the cycle it holds TICK_MAX-1.
REQ-014 While enable=0, the tick counter SHALL hold its value and no tick SHALL occur.
REQ-015 On each tick, the phase accumulator SHALL advance by phase_inc modulo 2^PHASE_W; the sample SHALL use the phase value before the add.
REQ-016 On each tick, amp SHALL be captured alongside the phase; later amp changes SHALL NOT affect that sample.
REQ-017 Table address SHALL be phase[PHASE_W-1 -: ADDR_W]; quadrant = address[ADDR_W-1:ADDR_W-2]; k = address[ADDR_W-3:0].
REQ-018 Internal quarter LUT SHALL hold Q+1 entries, q[j] = round(HALF*sin(pi*j/(2Q))), j = 0..Q, generated at elaboration.
REQ-019 Magnitude m SHALL be q[k] in quadrants 0 and 2, and q[Q-k] in quadrants 1 and 3.
REQ-020 Scaled value s SHALL be (m*(amp+1))>>8, computed at full width (DATA_W+8 bits), no truncation before the shift.
REQ-021 Output SHALL be HALF+s in quadrants 0-1 and HALF-s in quadrants 2-3; no overflow is possible.
REQ-022 Pipeline SHALL be 3 stages: phase/amp capture, LUT read, scale. widthSine updates and sample_valid pulses exactly 3 cycles after the tick cycle.
REQ-023 Between updates, widthSine SHALL hold its value and sample_valid SHALL be 0.
REQ-024 sync_zero=1 SHALL clear the phase accumulator and tick counter to 0 on that edge.
REQ-025 If sync_zero and tick coincide, sync_zero SHALL win; that tick is suppressed and no sample is issued for it.
REQ-026 Samples already in the pipeline SHALL complete normally across sync_zero and enable=0.
REQ-027 A phase_inc change SHALL take effect at the next tick only.

Reset
REQ-028 While rst=1: tick counter=0, phase=0, pipeline valids=0, widthSine=0, sample_valid=0; in-flight samples discarded.
REQ-029 rst SHALL take priority over sync_zero and enable.
REQ-030 Reset SHALL be synchronous: state changes only on a clk edge with rst=1.

Verification
Params: TICK_MAX=4, ADDR_W=4, DATA_W=8, PHASE_W=8, giving HALF=127 and q = {0,49,90,117,127}.
REQ-031 Reset: rst high 3 cycles, then enable=1 -> widthSine=0, sample_valid=0 until first tick; first valid pulse 3 cycles after tick (cycle 6 after rst release if counter starts at 0).
REQ-032 Full wave: phase_inc=16, amp=255 -> 16 consecutive samples 127,176,217,244,254,244,217,176,127,78,37,10,0,10,37,78, then repeat.
REQ-033 Scaling: amp=127, phase_inc=16 -> sample at address 4 = 190, address 12 = 64.
REQ-034 Sync collision: sync_zero asserted in a tick cycle -> no sample_valid pulse for that tick; next sample = 127 (phase 0).
REQ-035 Gating: enable low for 10 cycles mid-count -> widthSine holds, no pulses; resume continues counter from its held value; in-flight sample still emitted.
REQ-036 Reset mid-pipeline: rst one cycle after a tick -> no pulse emitted, widthSine=0.

Source files
------------

// File: rtl/sine_width_gen.sv
// Sine-shaped PWM width generator: tick-paced phase accumulator, quarter-wave LUT, amplitude scaling.
// Latency: widthSine/sample_valid update 3 clk cycles after each tick.
// Backpressure: none; free-running, enable gates the tick counter and sync_zero restarts the phase.
module sine_width_gen #(
    parameter int TICK_MAX = 1000,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int PHASE_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [7:0]         amp,
    input  logic               sync_zero,
    output logic [DATA_W-1:0]  widthSine,
    output logic               sample_valid
);

    localparam int Q      = 2 ** (ADDR_W - 2);
    localparam int CNT_W  = $clog2(TICK_MAX);
    localparam int PROD_W = DATA_W + 8;
    localparam logic [DATA_W-1:0] HALF = {1'b0, {(DATA_W-1){1'b1}}};
    localparam real PI = 3.14159265358979323846;

    // Taylor series is ample over [0, pi/2] and keeps the table free of tool math libraries.
    function automatic real sin_taylor(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n < 14; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic logic [DATA_W-1:0] qval(input int j);
        real v;
        v = real'(HALF) * sin_taylor(PI * real'(j) / (2.0 * real'(Q)));
        return DATA_W'(longint'($floor(v + 0.5)));
    endfunction

    logic [DATA_W-1:0] qlut [0:Q];

    for (genvar j = 0; j <= Q; j++) begin : g_lut
        localparam logic [DATA_W-1:0] QV = qval(j);
        assign qlut[j] = QV;
    end

    logic [CNT_W-1:0]   tick_cnt;
    logic [PHASE_W-1:0] phase;
    logic               tick;
    logic               tick_take;

    assign tick      = enable && (tick_cnt == CNT_W'(TICK_MAX - 1));
    assign tick_take = tick && !sync_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            phase    <= '0;
        end else if (sync_zero) begin
            tick_cnt <= '0;
            phase    <= '0;
        end else if (enable) begin
            if (tick) begin
                tick_cnt <= '0;
                phase    <= phase + phase_inc;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1: capture pre-add phase address and amplitude for this sample.
    logic              s1_vld;
    logic [ADDR_W-1:0] s1_addr;
    logic [7:0]        s1_amp;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_addr <= '0;
            s1_amp  <= '0;
        end else begin
            s1_vld <= tick_take;
            if (tick_take) begin
                s1_addr <= phase[PHASE_W-1 -: ADDR_W];
                s1_amp  <= amp;
            end
        end
    end

    // Stage 2: quarter-wave lookup, mirrored index in odd quadrants.
    logic [ADDR_W-3:0] s1_k;
    logic [ADDR_W-2:0] lut_idx;

    assign s1_k    = s1_addr[ADDR_W-3:0];
    assign lut_idx = s1_addr[ADDR_W-2] ? ((ADDR_W-1)'(Q) - {1'b0, s1_k}) : {1'b0, s1_k};

    logic              s2_vld;
    logic [DATA_W-1:0] s2_mag;
    logic [1:0]        s2_quad;
    logic [7:0]        s2_amp;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_mag  <= '0;
            s2_quad <= '0;
            s2_amp  <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_mag  <= qlut[lut_idx];
                s2_quad <= s1_addr[ADDR_W-1 -: 2];
                s2_amp  <= s1_amp;
            end
        end
    end

    // Stage 3: scale by (amp+1)/256 at full product width, then offset around mid-scale.
    logic [DATA_W-1:0] scaled;

    assign scaled = DATA_W'((PROD_W'(s2_mag) * (PROD_W'(s2_amp) + PROD_W'(1))) >> 8);

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_valid <= 1'b0;
            widthSine    <= '0;
        end else begin
            sample_valid <= s2_vld;
            if (s2_vld) begin
                widthSine <= s2_quad[1] ? (HALF - scaled) : (HALF + scaled);
            end
        end
    end

endmodule
